ddr2_blk_rdwr_fifo_72b_2_64b: RTL and testbench



---
 rtl/ddr2_blk_rdwr_fifo_72b_2_64b_pkg.sv | 13 +
 rtl/ddr2_blk_rdwr_fifo_72b_2_64b_fallthrough_small_fifo.sv | 56 +++++
 rtl/ddr2_blk_rdwr_fifo_72b_2_64b.sv | 101 ++++++++++
 tb/tb_ddr2_blk_rdwr_fifo_72b_2_64b.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b_pkg.sv
// Shared widths and byte-count constants for the 72-to-64 bit DDR2 read-path width converter.
package ddr2_blk_rdwr_fifo_72b_2_64b_pkg;

  localparam int IN_W            = 72;
  localparam int OUT_W           = 64;
  localparam int FIFO_DEPTH_BITS = 4;

  typedef logic [3:0] byte_cnt_t;

  localparam byte_cnt_t CNT_NONE = 4'd0;
  localparam byte_cnt_t CNT_FULL = 4'd8;

endpackage

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b_fallthrough_small_fifo.sv
// Small fall-through FIFO: the head word is visible combinationally one cycle after its write edge.
// Pops happen only on i_rd_en. Writes made while the FIFO is full are dropped.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_nearly_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_L = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_LVL  = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0]          r_mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_depth;
  logic                      w_wr;
  logic                      w_rd;

  assign o_empty       = (r_depth == '0);
  assign o_nearly_full = (r_depth >= NF_LVL);
  assign w_wr          = i_wr_en & (r_depth != DEPTH_L);
  assign w_rd          = i_rd_en & ~o_empty;
  assign o_dout        = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_depth  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_depth <= r_depth + 1'b1;
        2'b01:   r_depth <= r_depth - 1'b1;
        default: r_depth <= r_depth;
      endcase
    end
  end

endmodule

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b.sv
// Repacks 72-bit DDR2 read words into a gap-free MSB-first 64-bit stream (8 in -> 9 out).
// Fall-through output: rd_data valid whenever empty=0; i_flush releases a zero-padded partial tail.
module ddr2_blk_rdwr_fifo_72b_2_64b
  import ddr2_blk_rdwr_fifo_72b_2_64b_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IN_W-1:0]  i_wr_data,
  input  logic             i_wr_en,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [OUT_W-1:0] o_rd_data,
  output logic [OUT_W-1:0] o_rd_data_d1,
  output logic             o_empty,
  input  logic             i_flush
);

  logic [OUT_W-1:0] r_residual;
  byte_cnt_t        r_cnt;
  logic [OUT_W-1:0] r_rd_data_d1;

  logic             w_fifo_empty;
  logic [IN_W-1:0]  w_head;
  logic [6:0]       w_shr;
  logic [6:0]       w_shl;
  logic [IN_W-1:0]  w_head_shr;
  logic [IN_W-1:0]  w_head_shl;
  logic             w_avail;
  logic             w_pop;
  logic [OUT_W-1:0] w_rd_data;
  logic [OUT_W-1:0] w_res_nxt;
  byte_cnt_t        w_cnt_nxt;

  fallthrough_small_fifo #(
    .WIDTH          (IN_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_din         (i_wr_data),
    .i_wr_en       (i_wr_en),
    .i_rd_en       (w_pop),
    .o_dout        (w_head),
    .o_nearly_full (o_full),
    .o_empty       (w_fifo_empty)
  );

  // Head bytes not completing this output word are kept, left-aligned, as the next residual.
  assign w_shr      = {r_cnt, 3'b000} + 7'd8;
  assign w_shl      = 7'd56 - {r_cnt, 3'b000};
  assign w_head_shr = w_head >> w_shr;
  assign w_head_shl = w_head << w_shl;

  always_comb begin
    w_avail   = 1'b0;
    w_pop     = 1'b0;
    w_rd_data = '0;
    w_res_nxt = r_residual;
    w_cnt_nxt = r_cnt;
    if (r_cnt == CNT_FULL) begin
      w_avail   = 1'b1;
      w_rd_data = r_residual;
      if (i_rd_en) begin
        w_res_nxt = '0;
        w_cnt_nxt = CNT_NONE;
      end
    end else if (!w_fifo_empty) begin
      w_avail   = 1'b1;
      w_rd_data = r_residual | w_head_shr[OUT_W-1:0];
      if (i_rd_en) begin
        w_pop     = 1'b1;
        w_res_nxt = w_head_shl[OUT_W-1:0];
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end else if (i_flush && (r_cnt != CNT_NONE)) begin
      w_avail   = 1'b1;
      w_rd_data = r_residual;
      if (i_rd_en) begin
        w_res_nxt = '0;
        w_cnt_nxt = CNT_NONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_residual   <= '0;
      r_cnt        <= CNT_NONE;
      r_rd_data_d1 <= '0;
    end else begin
      r_residual   <= w_res_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rd_data_d1 <= w_rd_data;
    end
  end

  assign o_rd_data    = w_rd_data;
  assign o_rd_data_d1 = r_rd_data_d1;
  assign o_empty      = ~w_avail;

endmodule

// File: tb/tb_ddr2_blk_rdwr_fifo_72b_2_64b.sv
// Bench for the 72-to-64 converter: a byte-queue reference model predicts empty/rd_data/rd_data_d1 each cycle.
module tb_ddr2_blk_rdwr_fifo_72b_2_64b;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic [71:0] wr_data = '0;
  logic        full;
  logic        empty;
  logic [63:0] rd_data;
  logic [63:0] rd_data_d1;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mq[$];
  logic [63:0] prev_exp = '0;

  always #5 clk = ~clk;

  ddr2_blk_rdwr_fifo_72b_2_64b dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_data    (wr_data),
    .i_wr_en      (wr_en),
    .o_full       (full),
    .i_rd_en      (rd_en),
    .o_rd_data    (rd_data),
    .o_rd_data_d1 (rd_data_d1),
    .o_empty      (empty),
    .i_flush      (flush)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Next output word: the first eight queued bytes, MSB first, zero-padded if fewer remain.
  function automatic logic [63:0] exp_word();
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i < mq.size()) w[63-8*i -: 8] = mq[i];
    return w;
  endfunction

  function automatic bit exp_avail(input bit fl);
    return (mq.size() >= 8) || (fl && (mq.size() > 0));
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit wr, input logic [71:0] wd, input bit rd, input bit fl, output bit acc);
    bit          av;
    logic [63:0] ew;
    int          n;
    @(negedge clk);
    acc     = wr && !full;
    wr_en   = acc;
    wr_data = wd;
    rd_en   = rd;
    flush   = fl;
    #1;
    av = exp_avail(fl);
    ew = av ? exp_word() : 64'h0;
    chk("empty", {71'h0, empty}, {71'h0, !av});
    chk("rd_data", {8'h0, rd_data}, {8'h0, ew});
    chk("rd_data_d1", {8'h0, rd_data_d1}, {8'h0, prev_exp});
    @(posedge clk);
    prev_exp = ew;
    if (rd && av) begin
      n = (mq.size() < 8) ? mq.size() : 8;
      for (int i = 0; i < n; i++) void'(mq.pop_front());
    end
    if (acc)
      for (int i = 0; i < 9; i++) mq.push_back(wd[71-8*i -: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_empty", {71'h0, empty}, 72'h1);
    chk("rst_rd_data", {8'h0, rd_data}, 72'h0);
    chk("rst_d1", {8'h0, rd_data_d1}, 72'h0);
    chk("rst_full", {71'h0, full}, 72'h0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    prev_exp = '0;
  endtask

  function automatic logic [71:0] seq_word(input int k);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[71-8*i -: 8] = 8'(9*k + i);
    return w;
  endfunction

  function automatic logic [71:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  initial begin
    bit          acc;
    int          written;
    int          budget;
    logic [71:0] wv;

    // Reset values and idle reads
    do_reset();
    repeat (3) cycle(0, '0, 1, 0, acc);

    // Full-ratio stream: 8 sequential words -> 9 output words
    for (int k = 0; k < 8; k++) cycle(1, seq_word(k), 0, 0, acc);
    #1;
    chk("ratio_first", {8'h0, rd_data}, {8'h0, 64'h0001020304050607});
    for (int k = 0; k < 8; k++) cycle(0, '0, 1, 0, acc);
    #1;
    chk("ratio_last", {8'h0, rd_data}, {8'h0, 64'h4041424344454647});
    cycle(0, '0, 1, 0, acc);
    repeat (2) cycle(0, '0, 1, 0, acc);

    // Flush of a partial tail
    do_reset();
    cycle(1, 72'h112233445566778899, 0, 0, acc);
    cycle(0, '0, 1, 0, acc);
    cycle(0, '0, 0, 1, acc);
    #1;
    chk("flush_tail", {8'h0, rd_data}, {8'h0, 64'h9900000000000000});
    cycle(0, '0, 1, 1, acc);
    cycle(0, '0, 0, 1, acc);

    // Backpressure: nearly_full after 15 words of a 16-deep FIFO
    do_reset();
    for (int k = 0; k < 15; k++) begin
      cycle(1, rand_word(), 0, 0, acc);
      chk("bp_accept", {71'h0, acc}, 72'h1);
      #1;
      chk("bp_full", {71'h0, full}, {71'h0, (k + 1) >= 15});
    end
    repeat (16) cycle(0, '0, 1, 0, acc);
    #1;
    chk("bp_full_clear", {71'h0, full}, 72'h0);

    // Random gaps on both sides over 1000 words, then flush-drain the tail
    do_reset();
    written = 0;
    budget  = 0;
    while (written < 1000 && budget < 20000) begin
      cycle($urandom_range(0, 9) < 6, rand_word(), $urandom_range(0, 9) < 7, 0, acc);
      if (acc) written++;
      budget++;
    end
    chk("rand_written", 72'(written), 72'd1000);
    budget = 0;
    while (mq.size() > 0 && budget < 2000) begin
      cycle(0, '0, 1, 1, acc);
      budget++;
    end
    chk("rand_drained", 72'(mq.size()), 72'd0);
    cycle(0, '0, 1, 1, acc);

    // Reset mid-stream with 5 residual bytes and 3 words queued
    do_reset();
    for (int k = 0; k < 8; k++) cycle(1, rand_word(), 0, 0, acc);
    repeat (5) cycle(0, '0, 1, 0, acc);
    do_reset();
    wv = rand_word();
    cycle(1, wv, 0, 0, acc);
    cycle(0, '0, 0, 0, acc);
    #1;
    chk("realign", {8'h0, rd_data}, {8'h0, wv[71:8]});
    cycle(0, '0, 1, 0, acc);
    cycle(0, '0, 0, 0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
